alu_req_arbiter: RTL
====================

// Module: alu_req_arbiter
// PURPOSE
//  Shares one signed ALU_TOP instance between NREQ=2 requesters. Round-robin arbitration,
//  valid/ready handshake per requester, operand/opcode registering toward the ALU, ALU latency
//  counting, result-unit selection, and a tagged response channel. Sits between command
//  sources (e.g. sequencer, host regs) and the shared ALU datapath.
// PARAMETERS
//  DW       16  operand/result width (signed two's complement)
//  ALU_LAT  1   cycles from ALU inputs stable to ALU outputs valid (ALU_TOP registers once)
// PORTS
//  clk          in   1     system clock, rising edge
//  rst          in   1     asynchronous reset, active-high
//  req_valid    in   2     per-requester command valid
//  req_ready    out  2     per-requester accept (one-hot or zero)
//  req_a        in   2*DW  operand A per requester, [DW-1:0]=req0
//  req_b        in   2*DW  operand B per requester
//  req_fun      in   2*4   ALU_FUN per requester, [3:0]=req0
//  alu_a        out  DW    to ALU_TOP.A (registered)
//  alu_b        out  DW    to ALU_TOP.B (registered)
//  alu_fun      out  4     to ALU_TOP.ALU_FUN (registered)
//  arith_out/logic_out/cmp_out/shift_out  in DW  ALU_TOP result buses
//  arith_flag/logic_flag/cmp_flag/shift_flag in 1  ALU_TOP unit flags
//  rsp_valid    out  1     response valid
//  rsp_ready    in   1     response accept
//  rsp_id       out  1     requester index of response
//  rsp_data     out  DW    selected result
//  rsp_flag     out  1     selected unit flag
//  rsp_err      out  1     1 = divide-by-zero rejected, rsp_data=0
//  busy         out  1     state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE; req_ready=0; alu_a=alu_b=0; alu_fun=4'b1000 (CMP no-op); rsp_*=0;
//   busy=0; rr_last=1 (so req0 wins first tie). Reset mid-op aborts; nothing is replayed.
//  FSM: IDLE -> EXEC -> RESP -> IDLE; IDLE -> RESP directly on div-by-zero.
//  IDLE: grant = first valid requester after rr_last (round-robin); req_ready combinationally
//   high for granted index only; no valid -> req_ready=0. Handshake = valid&ready (edge T):
//   latch a/b/fun into alu_*, latch id, rr_last<=id, cnt<=ALU_LAT.
//  Div-by-zero: fun==4'b0011 && b==0 -> alu_* NOT updated; go RESP with rsp_err=1,
//   rsp_data=0, rsp_flag=0; rsp_valid in cycle T+1.
//  EXEC: alu_* held stable; cnt decrements each cycle; at cnt==0 sample result selected by
//   alu_fun[3:2]: 00 arith, 01 logic, 10 cmp, 11 shift (data+flag) -> RESP.
//   ALU_LAT=1: accept edge T, EXEC cycles T+1..T+2, rsp_valid first high in cycle T+3.
//  RESP: rsp_valid=1; rsp_* held stable until rsp_valid&rsp_ready; then IDLE. req_ready=0
//   throughout EXEC/RESP (one op in flight, no accept in the cycle rsp handshakes).
//  alu_* retain last issued values while IDLE/RESP. Widths: no extension; DW passes through.
//  Requester changing req_* while valid&!ready is allowed; only accepted values are used.
//  Both valid every cycle -> strict alternation 0,1,0,1... Starvation-free.
// STRUCTURE
//  Package alu_pkg: FUN_* opcode constants (4'b0000..4'b1111), unit-select codes
//   (UNIT_ARITH=2'b00..UNIT_SHIFT=2'b11), state enum encodings, FUN_NOP=4'b1000.
//  Sub-module rr_arb2 (2-way round-robin grant from valid + rr_last); rest in top.
//  Bench instantiates alu_req_arbiter + ALU_TOP with ALU_TOP reset driven as ~rst.
// TESTING
//  1 Single op: req0 a=-10 b=-5 fun=0000 -> rsp_valid at T+3, id=0, data=-15, err=0.
//  2 Contention: both valid; req0 a=3 b=4 fun=0010, req1 a=20 b=4 fun=0011 ->
//    responses in order id0 data=12, then id1 data=5; repeat -> id0 granted again.
//  3 Div-by-zero: req1 a=7 b=0 fun=0011 -> rsp_valid at T+1, err=1, data=0, alu_* unchanged.
//  4 Backpressure: rsp_ready=0 for 5 cycles on a=6 b=3 fun=0101 -> data=7 held stable,
//    req_ready=0 throughout; accepted on rsp_ready=1 then IDLE.
//  5 Unit select: fun=1010 a=5 b=1 -> data=cmp_out (2); fun=1101 a=8 b=1 -> data=shift_out.
//  6 Reset mid-EXEC: assert rst during EXEC -> same cycle busy=0, rsp_valid=0,
//    alu_fun=1000; after release, req0 wins first grant.

Source files
------------

// File: rtl/alu_pkg.sv
// Opcodes, result-unit codes and FSM encodings shared by the ALU request arbiter.
package alu_pkg;

    localparam logic [3:0] FUN_ADD  = 4'b0000;
    localparam logic [3:0] FUN_SUB  = 4'b0001;
    localparam logic [3:0] FUN_MUL  = 4'b0010;
    localparam logic [3:0] FUN_DIV  = 4'b0011;
    localparam logic [3:0] FUN_AND  = 4'b0100;
    localparam logic [3:0] FUN_OR   = 4'b0101;
    localparam logic [3:0] FUN_XOR  = 4'b0110;
    localparam logic [3:0] FUN_NOT  = 4'b0111;
    localparam logic [3:0] FUN_CMP  = 4'b1000;
    localparam logic [3:0] FUN_EQ   = 4'b1001;
    localparam logic [3:0] FUN_GT   = 4'b1010;
    localparam logic [3:0] FUN_LT   = 4'b1011;
    localparam logic [3:0] FUN_SRL  = 4'b1100;
    localparam logic [3:0] FUN_SLL  = 4'b1101;
    localparam logic [3:0] FUN_SRA  = 4'b1110;
    localparam logic [3:0] FUN_ROL  = 4'b1111;

    // Harmless compare with no side effects; parked on the ALU while idle after reset.
    localparam logic [3:0] FUN_NOP  = FUN_CMP;

    localparam logic [1:0] UNIT_ARITH = 2'b00;
    localparam logic [1:0] UNIT_LOGIC = 2'b01;
    localparam logic [1:0] UNIT_CMP   = 2'b10;
    localparam logic [1:0] UNIT_SHIFT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    function automatic logic [1:0] unit_of(input logic [3:0] fun);
        return fun[3:2];
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: the requester after rr_last wins a tie.
// Latency: combinational, zero cycles.
// Backpressure: none; grant is a pure function of valid and rr_last.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       rr_last,
    output logic [1:0] grant,
    output logic       gnt_id,
    output logic       gnt_vld
);

    always_comb begin
        grant = 2'b00;
        if (rr_last) begin
            if (valid[0])      grant = 2'b01;
            else if (valid[1]) grant = 2'b10;
        end else begin
            if (valid[1])      grant = 2'b10;
            else if (valid[0]) grant = 2'b01;
        end
    end

    assign gnt_id  = grant[1];
    assign gnt_vld = |grant;

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one ALU between two requesters with round-robin grant and a tagged response.
// Latency: accept to rsp_valid is ALU_LAT+2 cycles; divide-by-zero answers after one cycle.
// Backpressure: one op in flight; req_ready stays low until the response is taken.
module alu_req_arbiter
    import alu_pkg::*;
#(
    parameter int DW      = 16,
    parameter int ALU_LAT = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      req_valid,
    output logic [1:0]      req_ready,
    input  logic [2*DW-1:0] req_a,
    input  logic [2*DW-1:0] req_b,
    input  logic [7:0]      req_fun,
    output logic [DW-1:0]   alu_a,
    output logic [DW-1:0]   alu_b,
    output logic [3:0]      alu_fun,
    input  logic [DW-1:0]   arith_out,
    input  logic [DW-1:0]   logic_out,
    input  logic [DW-1:0]   cmp_out,
    input  logic [DW-1:0]   shift_out,
    input  logic            arith_flag,
    input  logic            logic_flag,
    input  logic            cmp_flag,
    input  logic            shift_flag,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic [DW-1:0]   rsp_data,
    output logic            rsp_flag,
    output logic            rsp_err,
    output logic            busy
);

    localparam int CW = (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);

    state_t          state;
    logic            rr_last;
    logic [CW-1:0]   cnt;

    logic [1:0]      grant;
    logic            gnt_id;
    logic            gnt_vld;
    logic [DW-1:0]   sel_a;
    logic [DW-1:0]   sel_b;
    logic [3:0]      sel_fun;
    logic            accept;
    logic            div_zero;
    logic [DW-1:0]   unit_dat;
    logic            unit_flg;

    rr_arb2 u_arb (
        .valid   (req_valid),
        .rr_last (rr_last),
        .grant   (grant),
        .gnt_id  (gnt_id),
        .gnt_vld (gnt_vld)
    );

    // Grant is only exposed in IDLE, so no accept can coincide with a response handshake.
    assign req_ready = (state == ST_IDLE && !rst) ? grant : 2'b00;
    assign accept    = (state == ST_IDLE) && gnt_vld;

    assign sel_a    = gnt_id ? req_a[2*DW-1:DW] : req_a[DW-1:0];
    assign sel_b    = gnt_id ? req_b[2*DW-1:DW] : req_b[DW-1:0];
    assign sel_fun  = gnt_id ? req_fun[7:4]     : req_fun[3:0];
    assign div_zero = (sel_fun == FUN_DIV) && (sel_b == '0);

    always_comb begin
        unit_dat = arith_out;
        unit_flg = arith_flag;
        case (unit_of(alu_fun))
            UNIT_ARITH: begin unit_dat = arith_out; unit_flg = arith_flag; end
            UNIT_LOGIC: begin unit_dat = logic_out; unit_flg = logic_flag; end
            UNIT_CMP:   begin unit_dat = cmp_out;   unit_flg = cmp_flag;   end
            UNIT_SHIFT: begin unit_dat = shift_out; unit_flg = shift_flag; end
            default:    begin unit_dat = arith_out; unit_flg = arith_flag; end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            rr_last   <= 1'b1;
            cnt       <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_fun   <= FUN_NOP;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
            rsp_flag  <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        rr_last <= gnt_id;
                        rsp_id  <= gnt_id;
                        if (div_zero) begin
                            // Rejected without touching the ALU; its inputs keep the last op.
                            state     <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_data  <= '0;
                            rsp_flag  <= 1'b0;
                        end else begin
                            state   <= ST_EXEC;
                            alu_a   <= sel_a;
                            alu_b   <= sel_b;
                            alu_fun <= sel_fun;
                            cnt     <= CW'(ALU_LAT);
                        end
                    end
                end
                ST_EXEC: begin
                    if (cnt == '0) begin
                        state     <= ST_RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_data  <= unit_dat;
                        rsp_flag  <= unit_flg;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state     <= ST_IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state != ST_IDLE);

endmodule
